instruction_fetch_queue: RTL and testbench

- In-order instruction fetch queue directly upstream of the decode/control stage.
- Generates sequential fetch PCs toward the instruction cache and buffers returned instruction words with their PCs.
- Presents the head entry and its pre-sliced decode fields (opcode, funct3, mod) to the control unit and dispatch.
- On a jump/branch redirect it flushes all queued and in-flight fetches and restarts at the target PC.

---
 rtl/instruction_fetch_queue_pkg.sv | 29 ++
 rtl/instruction_fetch_queue_if.sv | 33 +++
 rtl/instruction_fetch_queue_ram.sv | 54 +++++
 rtl/instruction_fetch_queue.sv | 114 +++++++++++
 tb/tb_instruction_fetch_queue.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_queue_pkg.sv
// Shared widths, reset PC, decode field positions and the entry record
// for the instruction fetch queue.
package instruction_fetch_queue_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC           = 32'd4;

  // Decode field slice positions within an instruction word
  localparam int OPC_LSB    = 0;
  localparam int OPC_MSB    = 6;
  localparam int F3_LSB     = 12;
  localparam int F3_MSB     = 14;
  localparam int MOD_HI_BIT = 30;
  localparam int MOD_LO_BIT = 25;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] instr;
    logic              filled;
  } ifq_entry_t;

  function automatic logic [1:0] mod_field(input logic [INST_W-1:0] instr);
    return {instr[MOD_HI_BIT], instr[MOD_LO_BIT]};
  endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Cache request/response bus plus the decode/dispatch side of the fetch
// queue. The queue is the master; the cache and decoder side is the slave.
interface instruction_fetch_queue_if;
  import instruction_fetch_queue_pkg::*;

  logic              cache_req;
  logic [XLEN-1:0]   cache_addr;
  logic              cache_gnt;
  logic              cache_rvalid;
  logic [INST_W-1:0] cache_rdata;

  logic              deq;
  logic              ifq_empty;
  logic [INST_W-1:0] instr_out;
  logic [XLEN-1:0]   pc_out;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [1:0]        mod;

  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;

  modport master (
    output cache_req, cache_addr, ifq_empty, instr_out, pc_out, opcode, funct3, mod,
    input  cache_gnt, cache_rvalid, cache_rdata, deq, redirect, redirect_pc
  );

  modport slave (
    input  cache_req, cache_addr, ifq_empty, instr_out, pc_out, opcode, funct3, mod,
    output cache_gnt, cache_rvalid, cache_rdata, deq, redirect, redirect_pc
  );

endinterface

// File: rtl/instruction_fetch_queue_ram.sv
// Entry storage for the fetch queue: PC written at allocation, instruction
// written at fill, filled flag cleared on dequeue or flush. Head is read
// combinationally so decode sees it with zero latency.
module ifq_entry_ram
  import instruction_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_we,
  input  logic [PTR_W-1:0]  alloc_idx,
  input  logic [XLEN-1:0]   alloc_pc,
  input  logic              fill_we,
  input  logic [PTR_W-1:0]  fill_idx,
  input  logic [INST_W-1:0] fill_instr,
  input  logic              clr_we,
  input  logic [PTR_W-1:0]  clr_idx,
  input  logic [PTR_W-1:0]  head_idx,
  output ifq_entry_t        head_entry
);

  logic [XLEN-1:0]   pc_q     [DEPTH];
  logic [INST_W-1:0] instr_q  [DEPTH];
  logic [DEPTH-1:0]  filled_q;

  // Entry writes; a fill marks the slot valid last so it wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q <= '0;
    end else if (flush) begin
      filled_q <= '0;
    end else begin
      if (clr_we) filled_q[clr_idx] <= 1'b0;
      if (alloc_we) begin
        pc_q[alloc_idx]     <= alloc_pc;
        filled_q[alloc_idx] <= 1'b0;
      end
      if (fill_we) begin
        instr_q[fill_idx]  <= fill_instr;
        filled_q[fill_idx] <= 1'b1;
      end
    end
  end

  assign head_entry = '{pc: pc_q[head_idx], instr: instr_q[head_idx], filled: filled_q[head_idx]};

endmodule

// File: rtl/instruction_fetch_queue.sv
// In-order instruction fetch queue: issues sequential fetch PCs, buffers
// returned words with their PCs, presents the head to decode, and flushes
// on redirect while discarding responses still in flight for the old path.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PTR_W    = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic                      clk,
  input logic                      rst_n,
  instruction_fetch_queue_if.master bus
);

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W+2:0] DROP_MAX  = (PTR_W + 3)'(2 * DEPTH);

  logic [PTR_W-1:0] alloc_ptr, fill_ptr, head_ptr;
  logic [PTR_W:0]   alloc_cnt;
  // Granted requests of the current epoch still waiting for data
  logic [PTR_W:0]   pend_cnt;
  logic [PTR_W+1:0] drop_cnt;
  logic [XLEN-1:0]  fetch_pc;

  logic             fire, rsp_keep, rsp_drop, deq_ok;
  logic [PTR_W+2:0] drop_sum;
  logic [PTR_W+1:0] drop_next;
  ifq_entry_t       head_entry;

  // Gated by rst_n so the request drops the moment reset is asserted.
  assign bus.cache_req  = rst_n && (alloc_cnt < DEPTH_CNT) && !bus.redirect;
  assign bus.cache_addr = fetch_pc;

  assign fire     = bus.cache_req && bus.cache_gnt;
  assign rsp_keep = bus.cache_rvalid && (drop_cnt == '0);
  assign rsp_drop = bus.cache_rvalid && (drop_cnt != '0);
  assign deq_ok   = bus.deq && !bus.ifq_empty && !bus.redirect;

  // Responses owed at a redirect: old drops plus this epoch's pending
  // requests, less whichever one (kept or dropped) lands this cycle.
  always_comb begin
    drop_sum  = {1'b0, drop_cnt} + (PTR_W + 3)'(pend_cnt) - (PTR_W + 3)'(bus.cache_rvalid);
    drop_next = (drop_sum > DROP_MAX) ? DROP_MAX[PTR_W+1:0] : drop_sum[PTR_W+1:0];
  end

  // Fetch PC: restart at target on redirect, otherwise advance per grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            fetch_pc <= RESET_PC;
    else if (bus.redirect) fetch_pc <= bus.redirect_pc;
    else if (fire)         fetch_pc <= fetch_pc + PC_INC;
  end

  // Ring pointers, occupancy and outstanding-request bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (bus.redirect) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= drop_next;
    end else begin
      if (fire)     alloc_ptr <= alloc_ptr + PTR_W'(1);
      if (rsp_keep) fill_ptr  <= fill_ptr + PTR_W'(1);
      if (deq_ok)   head_ptr  <= head_ptr + PTR_W'(1);
      if (rsp_drop) drop_cnt  <= drop_cnt - (PTR_W + 2)'(1);
      case ({fire, deq_ok})
        2'b10:   alloc_cnt <= alloc_cnt + (PTR_W + 1)'(1);
        2'b01:   alloc_cnt <= alloc_cnt - (PTR_W + 1)'(1);
        default: alloc_cnt <= alloc_cnt;
      endcase
      case ({fire, rsp_keep})
        2'b10:   pend_cnt <= pend_cnt + (PTR_W + 1)'(1);
        2'b01:   pend_cnt <= pend_cnt - (PTR_W + 1)'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

  ifq_entry_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (bus.redirect),
    .alloc_we   (fire),
    .alloc_idx  (alloc_ptr),
    .alloc_pc   (fetch_pc),
    .fill_we    (rsp_keep && !bus.redirect),
    .fill_idx   (fill_ptr),
    .fill_instr (bus.cache_rdata),
    .clr_we     (deq_ok),
    .clr_idx    (head_ptr),
    .head_idx   (head_ptr),
    .head_entry (head_entry)
  );

  assign bus.ifq_empty = !((alloc_cnt != '0) && head_entry.filled);
  assign bus.instr_out = head_entry.instr;
  assign bus.pc_out    = head_entry.pc;
  assign bus.opcode    = head_entry.instr[OPC_MSB:OPC_LSB];
  assign bus.funct3    = head_entry.instr[F3_MSB:F3_LSB];
  assign bus.mod       = mod_field(head_entry.instr);

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for the fetch queue: an in-order cache model with
// programmable latency, a scoreboard of expected head PCs popped on every
// accepted dequeue, and hand-timed checks around reset and redirect.
module tb_instruction_fetch_queue;
  import instruction_fetch_queue_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_queue_if bus ();

  instruction_fetch_queue #(
    .DEPTH    (4),
    .PTR_W    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] sb_pc [$];
  logic [31:0] cq_addr [$];
  int          cq_due [$];
  int          ncyc     = 0;
  int          lat      = 1;
  int          fire_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Cache model: in-order responses, presented at negedge, grants latched mid-cycle
  initial begin : cache_model
    logic [31:0] a;
    int          d;
    bus.cache_rvalid = 1'b0;
    bus.cache_rdata  = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      bus.cache_rvalid = 1'b0;
      if (!rst_n) begin
        cq_addr.delete();
        cq_due.delete();
      end else if (cq_addr.size() > 0 && cq_due[0] <= ncyc) begin
        a = cq_addr.pop_front();
        d = cq_due.pop_front();
        bus.cache_rvalid = 1'b1;
        bus.cache_rdata  = mem_word(a);
      end
      #2;
      if (rst_n && bus.cache_req && bus.cache_gnt) begin
        cq_addr.push_back(bus.cache_addr);
        cq_due.push_back(ncyc + lat);
        fire_cnt++;
      end
    end
  end

  // Scoreboard monitor: every accepted dequeue must match the next expected PC
  initial begin : monitor
    logic [31:0] ep, ei;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.deq && !bus.ifq_empty && !bus.redirect) begin
        if (sb_pc.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_deq: got pc=%h want=none", bus.pc_out);
        end else begin
          ep = sb_pc.pop_front();
          ei = mem_word(ep);
          chk("sb_pc",     bus.pc_out,            ep);
          chk("sb_instr",  bus.instr_out,         ei);
          chk("sb_opcode", 32'(bus.opcode),       32'(ei[6:0]));
          chk("sb_funct3", 32'(bus.funct3),       32'(ei[14:12]));
          chk("sb_mod",    32'(bus.mod),          32'({ei[30], ei[25]}));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc(input logic g, input logic d, input logic r = 1'b0,
                     input logic [31:0] rp = 32'h0);
    @(negedge clk);
    bus.cache_gnt   = g;
    bus.deq         = d;
    bus.redirect    = r;
    bus.redirect_pc = rp;
    #1;
  endtask

  task automatic wait_filled(input string name, input int maxc);
    int n = 0;
    while (bus.ifq_empty && n < maxc) begin
      cyc(1'b0, 1'b0);
      n++;
    end
    total++;
    if (bus.ifq_empty) begin
      bad++;
      $display("FAIL %s: got=still_empty want=filled within %0d cycles", name, maxc);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
  endtask

  initial begin : stim
    bus.cache_gnt   = 1'b0;
    bus.deq         = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cache_req", 32'(bus.cache_req), 32'd0);
    chk("rst_ifq_empty", 32'(bus.ifq_empty), 32'd1);
    chk("rst_instr_out", bus.instr_out, 32'h0);
    chk("rst_pc_out",    bus.pc_out,    32'h0);
    chk("rst_addr",      bus.cache_addr, 32'h0);

    // First fetch and fill-to-full with no dequeue
    sb_pc.push_back(32'h0);
    sb_pc.push_back(32'h4);
    sb_pc.push_back(32'h8);
    sb_pc.push_back(32'hC);
    lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.cache_gnt = 1'b1;
    #1;
    chk("first_req",  32'(bus.cache_req), 32'd1);
    chk("first_addr", bus.cache_addr, 32'h0);
    cyc(1'b1, 1'b0);
    chk("lat_empty_1", 32'(bus.ifq_empty), 32'd1);
    cyc(1'b1, 1'b0);
    chk("lat_empty_2", 32'(bus.ifq_empty), 32'd0);
    chk("first_pc",     bus.pc_out, 32'h0);
    chk("first_instr",  bus.instr_out, 32'h0000_0013);
    chk("first_opcode", 32'(bus.opcode), 32'h13);
    chk("first_funct3", 32'(bus.funct3), 32'h0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("full_req",  32'(bus.cache_req), 32'd0);
    chk("full_fires", 32'(fire_cnt), 32'd4);
    cyc(1'b1, 1'b0);
    chk("full_req_hold",  32'(bus.cache_req), 32'd0);
    chk("full_fires_hold", 32'(fire_cnt), 32'd4);
    cyc(1'b1, 1'b1);
    chk("deq_cycle_req", 32'(bus.cache_req), 32'd0);
    cyc(1'b1, 1'b0);
    chk("after_deq_req",  32'(bus.cache_req), 32'd1);
    chk("after_deq_addr", bus.cache_addr, 32'h10);
    sb_pc.push_back(32'h10);

    // Drain, then 3-cycle latency with dequeue held high across empty cycles
    repeat (4) cyc(1'b0, 1'b1);
    lat = 3;
    sb_pc.push_back(32'h14);
    sb_pc.push_back(32'h18);
    sb_pc.push_back(32'h1C);
    cyc(1'b1, 1'b1);
    chk("deq_on_empty", 32'(bus.ifq_empty), 32'd1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("lat3_empty", 32'(bus.ifq_empty), 32'd1);
    repeat (4) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    chk("lat3_drained_empty", 32'(bus.ifq_empty), 32'd1);
    chk("lat3_sb_left", 32'(sb_pc.size()), 32'd0);
    chk("lat3_fires", 32'(fire_cnt), 32'd8);

    // Redirect with two requests outstanding: their data must be discarded
    lat = 4;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 32'h100);
    chk("redir_req_low", 32'(bus.cache_req), 32'd0);
    lat = 1;
    cyc(1'b1, 1'b0);
    chk("redir_restart_req",  32'(bus.cache_req), 32'd1);
    chk("redir_restart_addr", bus.cache_addr, 32'h100);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("drop_beat1_empty", 32'(bus.ifq_empty), 32'd1);
    cyc(1'b0, 1'b0);
    chk("drop_beat2_empty", 32'(bus.ifq_empty), 32'd1);
    wait_filled("redir_fill_timeout", 10);
    chk("redir_first_pc",    bus.pc_out, 32'h100);
    chk("redir_first_instr", bus.instr_out, mem_word(32'h100));
    sb_pc.push_back(32'h100);
    sb_pc.push_back(32'h104);
    drain(3);
    chk("redir_fires", 32'(fire_cnt), 32'd12);

    // Redirect coincident with a valid dequeue and a kept response
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 32'h200);
    chk("coinc_head_valid", 32'(bus.ifq_empty), 32'd0);
    chk("coinc_req_low",    32'(bus.cache_req), 32'd0);
    cyc(1'b0, 1'b0);
    chk("coinc_flushed",  32'(bus.ifq_empty), 32'd1);
    chk("coinc_addr",     bus.cache_addr, 32'h200);
    chk("coinc_req",      32'(bus.cache_req), 32'd1);
    sb_pc.push_back(32'h200);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("coinc_not_dropped", 32'(bus.ifq_empty), 32'd0);
    chk("coinc_pc",          bus.pc_out, 32'h200);
    drain(1);

    // Asynchronous reset in the middle of a burst
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("prerst_filled", 32'(bus.ifq_empty), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req",   32'(bus.cache_req), 32'd0);
    chk("arst_empty", 32'(bus.ifq_empty), 32'd1);
    chk("arst_instr", bus.instr_out, 32'h0);
    chk("arst_pc",    bus.pc_out, 32'h0);
    chk("arst_addr",  bus.cache_addr, 32'h0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.cache_gnt = 1'b1;
    #1;
    chk("rel_req",  32'(bus.cache_req), 32'd1);
    chk("rel_addr", bus.cache_addr, 32'h0);
    sb_pc.push_back(32'h0);
    cyc(1'b0, 1'b0);
    wait_filled("rel_fill_timeout", 5);
    chk("rel_pc", bus.pc_out, 32'h0);
    drain(1);

    chk("sb_all_consumed", 32'(sb_pc.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
